dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder: the slave end of the CPU's data port (mem_r/mem_w, address, store data, DMType).
//  Services one load/store at a time with a configurable-latency ready handshake and sub-word access.
//  Performs byte/half/word alignment, sign/zero extension and misalignment/range checking.
//  Sits between the pipelined core's MEM stage and an internal word-organised RAM array.
// PARAMETERS
//  ADDR_W   10  word-address bits; array depth = 2**ADDR_W 32-bit words
//  LATENCY  2   cycles from request acceptance to mem_ready; legal range 1..7
// PORTS
//  clk        in   1   clock, all state updates on rising edge
//  reset      in   1   synchronous, active-high reset
//  mem_r      in   1   load request (level, held by initiator until mem_ready)
//  mem_w      in   1   store request (level, held by initiator until mem_ready)
//  addr_in    in   32  byte address
//  wdata_in   in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  dm_type    in   3   access type: DM_WORD / DM_HALF / DM_HALF_U / DM_BYTE / DM_BYTE_U
//  rdata_out  out  32  load data, extended per dm_type; held until the next response
//  mem_ready  out  1   one-cycle pulse: access complete, rdata_out/mem_err valid
//  mem_err    out  1   valid with mem_ready: access rejected (no array change, rdata_out=0)
//  busy       out  1   high in WAIT and RESP states
// BEHAVIOUR
//  Reset: state IDLE, rdata_out=0, mem_ready=0, mem_err=0, busy=0, latency counter=0;
//   array contents NOT cleared. Reset mid-access aborts it: pending store never commits.
//  FSM: IDLE -> WAIT on (mem_r|mem_w); latches addr, wdata, dm_type, op; cnt<=LATENCY-1.
//   WAIT: cnt decrements each cycle; at cnt==0 -> RESP (LATENCY==1 goes IDLE->RESP directly).
//   RESP: mem_ready=1 for this cycle only; store commits to array on this edge; -> IDLE.
//  Request is sampled only in IDLE; inputs changing during WAIT/RESP are ignored.
//  Request still asserted in the cycle after RESP is a NEW access (initiator must drop it).
//  Total latency: mem_ready asserts exactly LATENCY cycles after the accepting edge.
//  Error (mem_err=1, no write, rdata_out=0), checked on latched values:
//   mem_r & mem_w both high; half access with addr[0]=1; word access with addr[1:0]!=0;
//   addr[31:ADDR_W+2] != 0; dm_type not one of the five codes.
//  Store: word writes all 4 bytes; half writes bytes {addr[1],0}+{0,1} from wdata[15:0];
//   byte writes byte addr[1:0] from wdata[7:0]; untouched bytes preserved.
//  Load: selects lane by addr[1:0]; DM_BYTE/DM_HALF sign-extend, _U variants zero-extend.
//  Load of a word being written in the same RESP cycle cannot occur (single outstanding access).
// CONFIGURATION
//  DMEM_PERF_CNT_EN defined: adds outputs rd_cnt[31:0], wr_cnt[31:0], err_cnt[15:0];
//   each increments on mem_ready of a successful load / successful store / error; reset to 0;
//   wrap modulo 2**width. Undefined: ports and counters absent, behaviour otherwise identical.
// STRUCTURE
//  Shared header (alongside ctrl_encode_def.v): DM_WORD=3'b000, DM_HALF=3'b001,
//   DM_HALF_U=3'b010, DM_BYTE=3'b011, DM_BYTE_U=3'b100; FSM state codes IDLE/WAIT/RESP.
//  One sub-module: dmem_lane_align (combinational) -- byte enables + store lane shift,
//   load lane select + extension, misalignment flag. FSM, counter and array stay in top.
// TESTING
//  sw 0x1234_5678 @0x10, LATENCY=2 -> mem_ready 2 cycles after accept, err=0; lw @0x10 -> 0x1234_5678.
//  sb 0xAB @0x11 over that word, then lw @0x10 -> 0x1234_AB78; lb @0x11 -> 0xFFFF_FFAB; lbu -> 0x0000_00AB.
//  sh 0x8001 @0x12, lh @0x12 -> 0xFFFF_8001, lhu -> 0x0000_8001; lw @0x10 -> 0x8001_AB78.
//  lw @0x13, sh @0x11, mem_r&mem_w together, addr 0x0001_0000 (ADDR_W=10) -> mem_err=1, rdata 0, memory unchanged.
//  reset asserted in WAIT of sw 0xDEAD_BEEF @0x20 -> busy=0 next cycle, no mem_ready, later lw @0x20 returns prior value.
//  DMEM_PERF_CNT_EN: 3 loads, 2 stores, 1 error -> rd_cnt=3, wr_cnt=2, err_cnt=1; reset -> all 0.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: access-type codes,
// FSM state codes and a small helper for access-type validity.
package dmem_responder_pkg;

   // Access type presented by the core's MEM stage.
   typedef enum logic [2:0] {
      DM_WORD   = 3'b000,
      DM_HALF   = 3'b001,
      DM_HALF_U = 3'b010,
      DM_BYTE   = 3'b011,
      DM_BYTE_U = 3'b100
   } dm_type_e;

   // Responder FSM states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 3;

   // True for the five defined access-type codes.
   function automatic logic dm_known(input logic [2:0] dm);
      return (dm <= 3'd4);
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Data port between the core (master) and the memory responder (slave).
interface dmem_responder_if;
   logic        mem_r;
   logic        mem_w;
   logic [31:0] addr_in;
   logic [31:0] wdata_in;
   logic [2:0]  dm_type;
   logic [31:0] rdata_out;
   logic        mem_ready;
   logic        mem_err;
   logic        busy;

   modport master (
      output mem_r, mem_w, addr_in, wdata_in, dm_type,
      input  rdata_out, mem_ready, mem_err, busy
   );

   modport slave (
      input  mem_r, mem_w, addr_in, wdata_in, dm_type,
      output rdata_out, mem_ready, mem_err, busy
   );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: byte enables and store-data replication for
// writes, lane select plus sign/zero extension for reads, and the
// misalignment / unknown-type flags for the access being serviced.
module dmem_lane_align
   import dmem_responder_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  dm_type,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  byte_en,
   output logic [31:0] wdata_sh,
   output logic [31:0] rdata_ext,
   output logic        misalign,
   output logic        bad_type
);

   logic [15:0] half_sel;
   logic [7:0]  byte_sel;

   // Decode the access type into lane enables and the extended load value.
   always_comb begin
      byte_en   = 4'b0000;
      wdata_sh  = '0;
      rdata_ext = '0;
      misalign  = 1'b0;
      bad_type  = !dm_known(dm_type);
      half_sel  = addr_lo[1] ? rword[31:16] : rword[15:0];
      byte_sel  = rword[{addr_lo, 3'b000} +: 8];
      case (dm_type)
         DM_WORD: begin
            byte_en   = 4'b1111;
            wdata_sh  = wdata;
            rdata_ext = rword;
            misalign  = |addr_lo;
         end
         DM_HALF, DM_HALF_U: begin
            byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_sh  = {2{wdata[15:0]}};
            rdata_ext = (dm_type == DM_HALF) ? {{16{half_sel[15]}}, half_sel}
                                             : {16'h0000, half_sel};
            misalign  = addr_lo[0];
         end
         DM_BYTE, DM_BYTE_U: begin
            byte_en   = 4'b0001 << addr_lo;
            wdata_sh  = {4{wdata[7:0]}};
            rdata_ext = (dm_type == DM_BYTE) ? {{24{byte_sel[7]}}, byte_sel}
                                             : {24'h000000, byte_sel};
         end
         default: begin
            byte_en = 4'b0000;
         end
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time from the core,
// answers with a one-cycle mem_ready pulse LATENCY cycles after acceptance,
// and services byte/half/word accesses on a word-organised internal array.
// Optional build macro DMEM_PERF_CNT_EN adds load/store/error counters.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2
) (
   input  logic clk,
   input  logic reset,
   dmem_responder_if.slave bus
`ifdef DMEM_PERF_CNT_EN
   ,
   output logic [31:0] rd_cnt,
   output logic [31:0] wr_cnt,
   output logic [15:0] err_cnt
`endif
);

   localparam int DEPTH  = 2 ** ADDR_W;
   localparam int HI_LSB = ADDR_W + 2;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        addr_q, addr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [2:0]         dm_q, dm_d;
   logic               rd_q, rd_d;
   logic               wr_q, wr_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               ready_q, ready_d;
   logic               err_q, err_d;
   logic               busy_q, busy_d;

   logic [31:0]        mem_q [DEPTH];

   // In IDLE the access is judged straight from the bus so a LATENCY of 1
   // can answer on the accepting edge; afterwards the latched copy is used.
   logic               idle;
   logic               eff_r, eff_w;
   logic [31:0]        eff_addr, eff_wdata;
   logic [2:0]         eff_dm;
   logic [ADDR_W-1:0]  word_idx;
   logic [31:0]        rword;
   logic [3:0]         byte_en;
   logic [31:0]        wdata_sh, rdata_ext;
   logic               misalign, bad_type, range_bad, acc_err;
   logic               wr_commit;

   assign idle      = (state_q == IDLE);
   assign eff_r     = idle ? bus.mem_r    : rd_q;
   assign eff_w     = idle ? bus.mem_w    : wr_q;
   assign eff_addr  = idle ? bus.addr_in  : addr_q;
   assign eff_wdata = idle ? bus.wdata_in : wdata_q;
   assign eff_dm    = idle ? bus.dm_type  : dm_q;
   assign word_idx  = eff_addr[ADDR_W+1:2];
   assign rword     = mem_q[word_idx];
   assign range_bad = |eff_addr[31:HI_LSB];
   assign acc_err   = (eff_r & eff_w) | misalign | bad_type | range_bad;

   dmem_lane_align u_align (
      .addr_lo   (eff_addr[1:0]),
      .dm_type   (eff_dm),
      .wdata     (eff_wdata),
      .rword     (rword),
      .byte_en   (byte_en),
      .wdata_sh  (wdata_sh),
      .rdata_ext (rdata_ext),
      .misalign  (misalign),
      .bad_type  (bad_type)
   );

   // Next-state and registered-output computation for the access FSM.
   always_comb begin
      logic enter_resp;
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      dm_d       = dm_q;
      rd_d       = rd_q;
      wr_d       = wr_q;
      rdata_d    = rdata_q;
      ready_d    = 1'b0;
      err_d      = 1'b0;
      enter_resp = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.mem_r | bus.mem_w) begin
               addr_d  = bus.addr_in;
               wdata_d = bus.wdata_in;
               dm_d    = bus.dm_type;
               rd_d    = bus.mem_r;
               wr_d    = bus.mem_w;
               if (LATENCY == 1) begin
                  state_d    = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_W'(LATENCY - 1);
               end
            end
         end
         WAIT: begin
            // Leave on the cycle the count runs out so that mem_ready is
            // seen exactly LATENCY edges after the accepting edge.
            if (cnt_q == CNT_W'(1)) begin
               state_d    = RESP;
               cnt_d      = '0;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (enter_resp) begin
         ready_d = 1'b1;
         err_d   = acc_err;
         if (acc_err)
            rdata_d = '0;
         else if (eff_r)
            rdata_d = rdata_ext;
      end
   end

   assign busy_d = (state_d != IDLE);

   // FSM state, latched request and registered bus outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         dm_q    <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         dm_q    <= dm_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   // A store lands on the edge that closes RESP; a reset on that edge drops it.
   assign wr_commit = (state_q == RESP) & wr_q & ~err_q & ~reset;

   // Byte-enabled array write; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_commit) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b])
               mem_q[word_idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
         end
      end
   end

   assign bus.rdata_out = rdata_q;
   assign bus.mem_ready = ready_q;
   assign bus.mem_err   = err_q;
   assign bus.busy      = busy_q;

`ifdef DMEM_PERF_CNT_EN
   logic [31:0] rd_cnt_q, rd_cnt_d;
   logic [31:0] wr_cnt_q, wr_cnt_d;
   logic [15:0] err_cnt_q, err_cnt_d;

   // Classify each completed access while mem_ready is high; counters wrap.
   always_comb begin
      rd_cnt_d  = rd_cnt_q;
      wr_cnt_d  = wr_cnt_q;
      err_cnt_d = err_cnt_q;
      if (ready_q) begin
         if (err_q)
            err_cnt_d = err_cnt_q + 16'd1;
         else if (rd_q)
            rd_cnt_d = rd_cnt_q + 32'd1;
         else
            wr_cnt_d = wr_cnt_q + 32'd1;
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_cnt_q  <= '0;
         wr_cnt_q  <= '0;
         err_cnt_q <= '0;
      end else begin
         rd_cnt_q  <= rd_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign rd_cnt  = rd_cnt_q;
   assign wr_cnt  = wr_cnt_q;
   assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed accesses plus random traffic checked
// against a byte-array reference model of the data memory.
module tb_dmem_responder;
   import dmem_responder_pkg::*;

   localparam int LAT   = 2;
   localparam int AW    = 10;
   localparam int BYTES = 4 * (2 ** AW);

   logic clk;
   logic reset;
   int   total;
   int   bad;

   dmem_responder_if bus ();

`ifdef DMEM_PERF_CNT_EN
   logic [31:0] rd_cnt, wr_cnt;
   logic [15:0] err_cnt;
   int m_rd, m_wr, m_err;
`endif

   dmem_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef DMEM_PERF_CNT_EN
      ,
      .rd_cnt  (rd_cnt),
      .wr_cnt  (wr_cnt),
      .err_cnt (err_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] ref_mem [BYTES];

   function automatic int acc_size(input logic [2:0] dm);
      if (dm == DM_WORD) return 4;
      if (dm == DM_HALF || dm == DM_HALF_U) return 2;
      return 1;
   endfunction

   function automatic bit model_err(input bit r, input bit w, input logic [31:0] a,
                                    input logic [2:0] dm);
      if (r && w) return 1'b1;
      if (dm > 3'd4) return 1'b1;
      if (a >= 32'(BYTES)) return 1'b1;
      if ((a % 32'(acc_size(dm))) != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] dm);
      int     size;
      longint v;
      size = acc_size(dm);
      v = 0;
      for (int i = 0; i < size; i++)
         v += longint'(ref_mem[int'(a) + i]) << (8 * i);
      if ((dm == DM_HALF || dm == DM_BYTE) && v >= (longint'(1) << (8 * size - 1)))
         v -= longint'(1) << (8 * size);
      return v[31:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One complete access: drive, wait (bounded) for mem_ready, check, drop.
   task automatic access(input string tag, input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] dm,
                         output logic [31:0] rd_o);
      bit          exp_e;
      logic [31:0] exp_d;
      int          cyc;
      bit          got;
      exp_e = model_err(r, w, a, dm);
      exp_d = (!exp_e && r) ? model_load(a, dm) : 32'h0;
      @(negedge clk);
      bus.mem_r = r; bus.mem_w = w; bus.addr_in = a; bus.wdata_in = wd; bus.dm_type = dm;
      @(posedge clk);
      #1;
      chk($sformatf("%s.busy", tag), {31'b0, bus.busy}, 32'd1);
      cyc = 0; got = 0;
      while (!got && cyc < 16) begin
         if (bus.mem_ready) got = 1;
         else begin
            @(posedge clk); #1; cyc++;
         end
      end
      chk($sformatf("%s.latency", tag), got ? 32'(cyc + 1) : 32'd999, 32'(LAT));
      rd_o = bus.rdata_out;
      chk($sformatf("%s.err", tag), {31'b0, bus.mem_err}, {31'b0, exp_e});
      if (exp_e || r)
         chk($sformatf("%s.rdata", tag), bus.rdata_out, exp_d);
      bus.mem_r = 1'b0; bus.mem_w = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("%s.pulse", tag), {30'b0, bus.mem_ready, bus.busy}, 32'd0);
      if (!exp_e && w)
         for (int i = 0; i < acc_size(dm); i++)
            ref_mem[int'(a) + i] = 8'(wd >> (8 * i));
`ifdef DMEM_PERF_CNT_EN
      if (exp_e) m_err++;
      else if (r) m_rd++;
      else m_wr++;
`endif
      $display("%-10s r=%0d w=%0d addr=%h wd=%h dm=%0d -> rdata=%h err=%0d",
               tag, r, w, a, wd, dm, bus.rdata_out, bus.mem_err);
   endtask

`ifdef DMEM_PERF_CNT_EN
   task automatic chk_cnt(input string tag);
      chk($sformatf("%s.rd_cnt", tag), rd_cnt, 32'(m_rd));
      chk($sformatf("%s.wr_cnt", tag), wr_cnt, 32'(m_wr));
      chk($sformatf("%s.err_cnt", tag), {16'h0, err_cnt}, 32'(m_err & 16'hFFFF));
   endtask
`endif

   initial begin
      logic [31:0] rd;
      logic [31:0] a, wd;
      logic [2:0]  dm;
      bit          r, w;
      total = 0; bad = 0;
`ifdef DMEM_PERF_CNT_EN
      m_rd = 0; m_wr = 0; m_err = 0;
`endif
      reset = 1'b1;
      bus.mem_r = 1'b0; bus.mem_w = 1'b0;
      bus.addr_in = '0; bus.wdata_in = '0; bus.dm_type = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.rdata", bus.rdata_out, 32'h0);
      chk("rst.ready", {31'b0, bus.mem_ready}, 32'd0);
      chk("rst.err",   {31'b0, bus.mem_err}, 32'd0);
      chk("rst.busy",  {31'b0, bus.busy}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Initialise the low 64 bytes so every later load has known data.
      for (int i = 0; i < 16; i++)
         access("fill", 1'b0, 1'b1, 32'(4 * i), $urandom, DM_WORD, rd);

      // Directed sub-word sequence with literal expectations.
      access("sw10",  0, 1, 32'h10, 32'h1234_5678, DM_WORD, rd);
      access("lw10",  1, 0, 32'h10, 32'h0, DM_WORD, rd);
      chk("lw10.lit", rd, 32'h1234_5678);
      access("sb11",  0, 1, 32'h11, 32'h0000_00AB, DM_BYTE, rd);
      access("lw10b", 1, 0, 32'h10, 32'h0, DM_WORD, rd);
      chk("lw10b.lit", rd, 32'h1234_AB78);
      access("lb11",  1, 0, 32'h11, 32'h0, DM_BYTE, rd);
      chk("lb11.lit", rd, 32'hFFFF_FFAB);
      access("lbu11", 1, 0, 32'h11, 32'h0, DM_BYTE_U, rd);
      chk("lbu11.lit", rd, 32'h0000_00AB);
      access("sh12",  0, 1, 32'h12, 32'h0000_8001, DM_HALF, rd);
      access("lh12",  1, 0, 32'h12, 32'h0, DM_HALF, rd);
      chk("lh12.lit", rd, 32'hFFFF_8001);
      access("lhu12", 1, 0, 32'h12, 32'h0, DM_HALF_U, rd);
      chk("lhu12.lit", rd, 32'h0000_8001);
      access("lw10c", 1, 0, 32'h10, 32'h0, DM_WORD, rd);
      chk("lw10c.lit", rd, 32'h8001_AB78);

      // Rejected accesses leave memory untouched.
      access("lw13",  1, 0, 32'h13, 32'h0, DM_WORD, rd);
      access("sh11",  0, 1, 32'h11, 32'h0000_FFFF, DM_HALF, rd);
      access("rw10",  1, 1, 32'h10, 32'hFFFF_FFFF, DM_WORD, rd);
      access("oor",   1, 0, 32'h0001_0000, 32'h0, DM_WORD, rd);
      access("badty", 0, 1, 32'h10, 32'h0, 3'd6, rd);
      access("lw10d", 1, 0, 32'h10, 32'h0, DM_WORD, rd);
      chk("lw10d.lit", rd, 32'h8001_AB78);
`ifdef DMEM_PERF_CNT_EN
      chk_cnt("cnt1");
`endif

      // Reset during WAIT of a store: the store must never commit.
      @(negedge clk);
      bus.mem_w = 1'b1; bus.addr_in = 32'h20; bus.wdata_in = 32'hDEAD_BEEF; bus.dm_type = DM_WORD;
      @(posedge clk);
      #1;
      reset = 1'b1;
      bus.mem_w = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst.busy",  {31'b0, bus.busy}, 32'd0);
      chk("midrst.ready", {31'b0, bus.mem_ready}, 32'd0);
`ifdef DMEM_PERF_CNT_EN
      m_rd = 0; m_wr = 0; m_err = 0;
      chk_cnt("cntrst");
`endif
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("midrst.quiet", {31'b0, bus.mem_ready}, 32'd0);
      end
      $display("midrst     reset during WAIT of sw 0xDEADBEEF @0x20");
      access("lw20", 1, 0, 32'h20, 32'h0, DM_WORD, rd);

      // Random traffic against the byte-array model.
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            r = 1'b1; w = 1'b1;
         end else begin
            r = 1'($urandom_range(0, 1)); w = !r;
         end
         dm = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
         a  = 32'($urandom_range(0, 63));
         if ($urandom_range(0, 15) == 0)
            a = a | (32'h1 << $urandom_range(12, 31));
         wd = $urandom;
         access($sformatf("rnd%0d", n), r, w, a, wd, dm, rd);
      end
`ifdef DMEM_PERF_CNT_EN
      chk_cnt("cnt2");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
